// File: rtl/axi_burst_scheduler_pkg.sv
// Shared types and helpers for the AXI burst scheduler.
// States, grant encodings and the last-byte-address function.
package axi_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic GRANT_WR = 1'b1;
  localparam logic GRANT_RD = 1'b0;

  // Start is aligned down to the beat size before adding the span;
  // callers truncate to their address width, which gives the wrap.
  function automatic logic [63:0] last_addr(
    input logic [63:0] addr,
    input logic [3:0]  len,
    input logic [2:0]  size
  );
    logic [63:0] mask;
    logic [63:0] span;
    mask = (64'd1 << size) - 64'd1;
    span = {59'd0, ({1'b0, len} + 5'd1)} << size;
    return (addr & ~mask) + span - 64'd1;
  endfunction

endpackage

// File: rtl/axi_burst_scheduler_if.sv
// AW/AR request, W/R beat monitor and command bus of the scheduler.
// slave: scheduler side; master: requester/downstream side.
interface axi_burst_scheduler_if #(
  parameter int AXI_AWIDTH = 32
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [AXI_AWIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_AWIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  WVALID;
  logic                  WREADY;
  logic                  WLAST;
  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [AXI_AWIDTH-1:0] CMD_ADDR;
  logic [AXI_AWIDTH-1:0] CMD_LAST_ADDR;
  logic [3:0]            CMD_LEN;
  logic [2:0]            CMD_SIZE;

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE,
    input  ARVALID, ARADDR, ARLEN, ARSIZE,
    input  WVALID, WREADY, WLAST,
    input  RVALID, RREADY, RLAST,
    input  CMD_READY,
    output AWREADY, ARREADY,
    output CMD_VALID, CMD_WRITE, CMD_ADDR,
    output CMD_LAST_ADDR, CMD_LEN, CMD_SIZE
  );

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE,
    output ARVALID, ARADDR, ARLEN, ARSIZE,
    output WVALID, WREADY, WLAST,
    output RVALID, RREADY, RLAST,
    output CMD_READY,
    input  AWREADY, ARREADY,
    input  CMD_VALID, CMD_WRITE, CMD_ADDR,
    input  CMD_LAST_ADDR, CMD_LEN, CMD_SIZE
  );
endinterface

// File: rtl/axi_burst_scheduler_arbiter.sv
// Two-requester round-robin arbiter with registered last grant.
// Ports: clk, rst_n, arbitrate, req_wr/req_rd in; grant_wr/grant_rd out.
module axi_sched_arbiter
  import axi_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic arbitrate,
  input  logic req_wr,
  input  logic req_rd,
  output logic grant_wr,
  output logic grant_rd
);

  logic last_grant;

  // On a tie the side that did not win last time goes first.
  assign grant_wr = arbitrate & req_wr &
                    (~req_rd | (last_grant == GRANT_RD));
  assign grant_rd = arbitrate & req_rd &
                    (~req_wr | (last_grant == GRANT_WR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_RD;
    end else if (grant_wr) begin
      last_grant <= GRANT_WR;
    end else if (grant_rd) begin
      last_grant <= GRANT_RD;
    end
  end

endmodule

// File: rtl/axi_burst_scheduler.sv
// Single-outstanding AW/AR burst scheduler with beat-count checking.
// Ports: ACLK, ARESETN, bus (slave modport), BUSY, LEN_ERR.
module axi_burst_scheduler
  import axi_sched_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_burst_scheduler_if.slave  bus,
  output logic                  BUSY,
  output logic                  LEN_ERR
);

  logic [1:0]            state;
  logic [4:0]            beat_cnt;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  aw_ready;
  logic                  ar_ready;
  logic                  cmd_valid;
  logic                  cmd_write;
  logic [AXI_AWIDTH-1:0] cmd_addr;
  logic [AXI_AWIDTH-1:0] cmd_last;
  logic [3:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [AXI_AWIDTH-1:0] sel_addr;
  logic [3:0]            sel_len;
  logic [2:0]            sel_size;
  logic                  beat;
  logic                  beat_last;
  logic                  len_bad;

  axi_sched_arbiter u_arb (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .arbitrate (state == ST_IDLE),
    .req_wr    (bus.AWVALID),
    .req_rd    (bus.ARVALID),
    .grant_wr  (grant_wr),
    .grant_rd  (grant_rd)
  );

  assign sel_addr = grant_wr ? bus.AWADDR : bus.ARADDR;
  assign sel_len  = grant_wr ? bus.AWLEN  : bus.ARLEN;
  assign sel_size = grant_wr ? bus.AWSIZE : bus.ARSIZE;

  // Only the granted direction's beats are seen.
  assign beat = cmd_write ? (bus.WVALID & bus.WREADY)
                          : (bus.RVALID & bus.RREADY);
  assign beat_last = cmd_write ? bus.WLAST : bus.RLAST;
  assign len_bad = ({1'b0, beat_cnt} + 6'd1) !=
                   ({2'b0, cmd_len} + 6'd1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      aw_ready  <= 1'b0;
      ar_ready  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_last  <= '0;
      cmd_len   <= '0;
      cmd_size  <= '0;
      LEN_ERR   <= 1'b0;
    end else begin
      aw_ready <= 1'b0;
      ar_ready <= 1'b0;
      LEN_ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr | grant_rd) begin
            aw_ready  <= grant_wr;
            ar_ready  <= grant_rd;
            cmd_write <= grant_wr;
            cmd_addr  <= sel_addr;
            cmd_last  <= AXI_AWIDTH'(last_addr(
                           64'(sel_addr), sel_len, sel_size));
            cmd_len   <= sel_len;
            cmd_size  <= sel_size;
            state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          // First CMD cycle overlaps the xREADY pulse, so
          // CMD_VALID rises one cycle later.
          if (cmd_valid & bus.CMD_READY) begin
            cmd_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= ST_DATA;
          end else begin
            cmd_valid <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (beat_cnt != 5'd31) begin
              beat_cnt <= beat_cnt + 5'd1;
            end
            if (beat_last) begin
              LEN_ERR <= len_bad;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.AWREADY       = aw_ready;
  assign bus.ARREADY       = ar_ready;
  assign bus.CMD_VALID     = cmd_valid;
  assign bus.CMD_WRITE     = cmd_write;
  assign bus.CMD_ADDR      = cmd_addr;
  assign bus.CMD_LAST_ADDR = cmd_last;
  assign bus.CMD_LEN       = cmd_len;
  assign bus.CMD_SIZE      = cmd_size;
  assign BUSY              = (state != ST_IDLE);

endmodule
